// File: rtl/line_window_buffer.sv
// line_window_buffer: turns a raster pixel stream into zero-padded 3x3 windows.
// It keeps two W-entry line buffers (the two most recent rows) plus a two-column
// shift register for the row being received.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_FILL   | receiving row 0 and pixel (1,0); no window output yet
//   S_STREAM | each pixel (r+1,c+1) with c >= 0 produces window (r,c)
//   S_EOL    | input stalled; emit window (r,W-1), whose right column is padding
//   S_FLUSH  | input stalled; emit last-row windows, whose bottom row is padding
module line_window_buffer #(
   parameter int IMAGE_WIDTH  = 480,
   parameter int IMAGE_HEIGHT = 360,
   parameter int PIXEL_WIDTH  = 8
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic                                   i_pixel_valid,
   input  logic [PIXEL_WIDTH-1:0]                 i_pixel,
   output logic                                   o_pixel_ready,
   output logic [0:2][0:2][PIXEL_WIDTH-1:0]       o_window,
   output logic                                   o_window_valid,
   input  logic                                   i_window_ready,
   output logic                                   o_frame_done
);

   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int RW = $clog2(IMAGE_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   typedef enum logic [1:0] {S_FILL, S_STREAM, S_EOL, S_FLUSH} state_t;

   // One image column as seen by the window: [0] top, [1] middle, [2] bottom.
   typedef logic [0:2][PIXEL_WIDTH-1:0] col_t;
   typedef logic [0:2][0:2][PIXEL_WIDTH-1:0] win_t;

   state_t r_state;
   state_t w_state_next;

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_flush_col;
   logic          r_flush_done;

   // r_lb_top holds the older of the two stored rows, r_lb_mid the newer.
   logic [PIXEL_WIDTH-1:0] r_lb_top [0:IMAGE_WIDTH-1];
   logic [PIXEL_WIDTH-1:0] r_lb_mid [0:IMAGE_WIDTH-1];

   col_t r_sh1;
   col_t r_sh2;
   col_t w_new_col;

   win_t r_window;
   win_t w_stream_win;
   win_t w_eol_win;
   win_t w_flush_win;
   logic r_window_valid;
   logic r_frame_done;

   logic w_out_free;
   logic w_consume;
   logic w_accept;

   logic [CW-1:0] w_flush_idx_l;
   logic [CW-1:0] w_flush_idx_r;

   assign w_consume      = r_window_valid & i_window_ready;
   assign w_out_free     = !r_window_valid || i_window_ready;
   assign w_accept       = i_pixel_valid & o_pixel_ready;
   assign o_window       = r_window;
   assign o_window_valid = r_window_valid;
   assign o_frame_done   = r_frame_done;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; the row counter has already wrapped to 0 when the last row ends.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FILL: begin
            if (w_accept && r_row == ROW_ONE) begin
               w_state_next = S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_accept && r_col == COL_LAST) begin
               w_state_next = S_EOL;
            end
         end
         S_EOL: begin
            if (w_out_free) begin
               w_state_next = (r_row == '0) ? S_FLUSH : S_STREAM;
            end
         end
         S_FLUSH: begin
            if (r_flush_done && w_consume) begin
               w_state_next = S_FILL;
            end
         end
         default: w_state_next = S_FILL;
      endcase
   end

   // Input handshake: pixels are taken only while receiving and the output slot can advance.
   always_comb begin
      o_pixel_ready = 1'b0;
      if (!i_rst && (r_state == S_FILL || r_state == S_STREAM)) begin
         o_pixel_ready = w_out_free;
      end
   end

   // Raster position of the next incoming pixel.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Line buffers roll down one row per accepted pixel; no reset is needed because
   // stale rows are masked (row 1) or overwritten before they can reach a window.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_lb_top[r_col] <= r_lb_mid[r_col];
         r_lb_mid[r_col] <= i_pixel;
      end
   end

   // Column entering the window: the top tap is padding while row 1 arrives.
   always_comb begin
      w_new_col[0] = (r_row == ROW_ONE) ? '0 : r_lb_top[r_col];
      w_new_col[1] = r_lb_mid[r_col];
      w_new_col[2] = i_pixel;
   end

   // Last two columns of the current centre row.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sh1 <= '0;
         r_sh2 <= '0;
      end else if (w_accept) begin
         r_sh2 <= r_sh1;
         r_sh1 <= w_new_col;
      end
   end

   // Candidate windows for stream, end-of-line and flush phases.
   always_comb begin
      w_flush_idx_l = (r_flush_col == '0) ? '0 : r_flush_col - 1'b1;
      w_flush_idx_r = (r_flush_col == COL_LAST) ? r_flush_col : r_flush_col + 1'b1;
      for (int i = 0; i < 3; i++) begin
         w_stream_win[i][0] = (r_col == COL_ONE) ? '0 : r_sh2[i];
         w_stream_win[i][1] = r_sh1[i];
         w_stream_win[i][2] = w_new_col[i];
         w_eol_win[i][0]    = r_sh2[i];
         w_eol_win[i][1]    = r_sh1[i];
         w_eol_win[i][2]    = '0;
      end
      w_flush_win[0][0] = (r_flush_col == '0) ? '0 : r_lb_top[w_flush_idx_l];
      w_flush_win[0][1] = r_lb_top[r_flush_col];
      w_flush_win[0][2] = (r_flush_col == COL_LAST) ? '0 : r_lb_top[w_flush_idx_r];
      w_flush_win[1][0] = (r_flush_col == '0) ? '0 : r_lb_mid[w_flush_idx_l];
      w_flush_win[1][1] = r_lb_mid[r_flush_col];
      w_flush_win[1][2] = (r_flush_col == COL_LAST) ? '0 : r_lb_mid[w_flush_idx_r];
      w_flush_win[2]    = '0;
   end

   // Output window register, flush sequencing and end-of-frame pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_window       <= '0;
         r_window_valid <= 1'b0;
         r_frame_done   <= 1'b0;
         r_flush_col    <= '0;
         r_flush_done   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_consume) begin
            r_window_valid <= 1'b0;
         end
         case (r_state)
            S_STREAM: begin
               if (w_accept && r_col != '0) begin
                  r_window       <= w_stream_win;
                  r_window_valid <= 1'b1;
               end
            end
            S_EOL: begin
               if (w_out_free) begin
                  r_window       <= w_eol_win;
                  r_window_valid <= 1'b1;
               end
            end
            S_FLUSH: begin
               if (!r_flush_done) begin
                  if (w_out_free) begin
                     r_window       <= w_flush_win;
                     r_window_valid <= 1'b1;
                     if (r_flush_col == COL_LAST) begin
                        r_flush_col  <= '0;
                        r_flush_done <= 1'b1;
                     end else begin
                        r_flush_col <= r_flush_col + 1'b1;
                     end
                  end
               end else if (w_consume) begin
                  r_frame_done <= 1'b1;
                  r_flush_done <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 480: pixels per row, unpadded (W); W >= 2.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 360: rows per frame (H); H >= 2.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8: bits per pixel.
REQ-004 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 i_clk  in  1  clock; all logic on rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_pixel_valid  in  1  input pixel valid; raster order, row 0 first.
REQ-008 i_pixel  in  PIXEL_WIDTH  input pixel value.
REQ-009 o_pixel_ready  out  1  block accepts i_pixel this cycle when high with i_pixel_valid.
REQ-010 o_window  out  PIXEL_WIDTH x [0:2][0:2]  3x3 neighbourhood; [0][*] is the row above the centre, [*][0] the column left of it, [1][1] the centre.
REQ-011 o_window_valid  out  1  o_window holds a valid window.
REQ-012 i_window_ready  in  1  downstream filter stage consumes the window when high with o_window_valid.
REQ-013 o_frame_done  out  1  one-cycle pulse after the last window of a frame is consumed.

Function
REQ-014 SHALL emit exactly W*H windows per frame, centres (r,c) in raster order; any tap outside the image SHALL read 0 (zero padding).
REQ-015 SHALL store the two most recent complete rows in two W-entry line buffers plus the current row; no other frame storage.
REQ-016 States: FILL, STREAM, EOL, FLUSH; reset state FILL.
REQ-017 FILL: accept row 0 and pixel (1,0) with no window output; after accepting (1,0) go to STREAM.
REQ-018 STREAM: accepting pixel (r+1,c+1), c in 0..W-2, SHALL present window (r,c) with o_window_valid high on the next cycle (registered, 1-cycle latency).
REQ-019 After accepting pixel (r+1,W-1), go to EOL: the cycle after window (r,W-2) is consumed, present window (r,W-1); o_pixel_ready SHALL be 0 while in EOL.
REQ-020 Leaving EOL: if r+1 < H-1, return to STREAM at row r+1 (pixel (r+2,0) triggers nothing); if r+1 = H-1, go to FLUSH.
REQ-021 FLUSH: emit windows (H-1,0..W-1) with bottom row all zero, one per consumed handshake, no input accepted (o_pixel_ready = 0).
REQ-022 After the window (H-1,W-1) handshake: pulse o_frame_done for one cycle, clear all counters, return to FILL; the next frame SHALL be accepted from the following cycle.
REQ-023 Backpressure: while o_window_valid=1 and i_window_ready=0, o_window SHALL be held stable and o_pixel_ready SHALL be 0.
REQ-024 In FILL/STREAM, o_pixel_ready = !o_window_valid || i_window_ready.
REQ-025 o_window_valid SHALL fall the cycle after a handshake unless a new window is produced that cycle (full throughput: one window per cycle sustained).
REQ-026 Input gaps (i_pixel_valid=0) SHALL not advance any counter or state.
REQ-027 Row/column counters SHALL wrap at W-1 and H-1 exactly; no window or pixel beyond W*H per frame.

Reset
REQ-028 On i_rst=1 at a rising edge: state FILL, all counters 0, o_window_valid=0, o_frame_done=0, o_window all 0, o_pixel_ready=0 that cycle; o_pixel_ready=1 from the first cycle after i_rst falls.
REQ-029 Reset mid-frame SHALL discard the partial frame; line buffer contents need not clear but SHALL never appear in a window of the next frame.

Verification (W=4, H=3, pixel (r,c) = 16r+c+1)
REQ-030 Stream frame, ready always 1 -> first o_window_valid the cycle after the 6th accepted pixel; window (0,0) = [[0,0,0],[0,1,2],[0,17,18]].
REQ-031 Same frame -> exactly 12 windows; last (2,3) = [[19,20,0],[35,36,0],[0,0,0]]; o_frame_done one pulse after it.
REQ-032 Hold i_window_ready=0 for 5 cycles during window (1,1) -> o_window stable, o_pixel_ready=0, no pixel lost or duplicated.
REQ-033 Assert i_rst after 7 pixels, then send a full frame -> output identical to REQ-030/031.
REQ-034 Two back-to-back frames, random i_pixel_valid gaps and random i_window_ready -> 24 windows matching a zero-padded reference model, two o_frame_done pulses.
